// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, default width.
package mdu_sequencer_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Product/remainder register, multiplier/quotient shifter and the shared 33-bit adder/subtractor.
module mdu_datapath
    import mdu_sequencer_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             load_div,
    input  logic             load_sgn,
    input  logic             load_dz,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             calc_div,
    input  logic             neg_prod,
    input  logic             neg_quo,
    input  logic             neg_rem,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     op_a_s, op_b_s;
    logic [WIDTH+1:0]   sum_s;
    logic [2*WIDTH-1:0] prod_s;

    // Operand magnitudes; 0x80000000 stays as unsigned 2^31.
    always_comb begin
        a_mag_s = (load_sgn && srca[WIDTH-1]) ? -srca : srca;
        b_mag_s = (load_sgn && srcb[WIDTH-1]) ? -srcb : srcb;
    end

    // One adder serves both ops; for divide, sum_s[WIDTH+1] set means no borrow.
    always_comb begin
        if (calc_div) begin
            op_a_s = {acc_q, sh_q[WIDTH-1]};
            op_b_s = ~{1'b0, b_q};
        end else begin
            op_a_s = {1'b0, acc_q};
            op_b_s = sh_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}};
        end
        sum_s = {1'b0, op_a_s} + {1'b0, op_b_s} + {{(WIDTH+1){1'b0}}, calc_div};
    end

    // Load / iterate next-state.
    always_comb begin
        acc_d = acc_q;
        sh_d  = sh_q;
        b_d   = b_q;
        if (load) begin
            if (load_dz) begin
                acc_d = srca;
                sh_d  = {WIDTH{1'b1}};
                b_d   = {WIDTH{1'b0}};
            end else if (load_div) begin
                acc_d = {WIDTH{1'b0}};
                sh_d  = a_mag_s;
                b_d   = b_mag_s;
            end else begin
                acc_d = {WIDTH{1'b0}};
                sh_d  = b_mag_s;
                b_d   = a_mag_s;
            end
        end else if (step) begin
            if (calc_div) begin
                if (sum_s[WIDTH+1]) begin
                    acc_d = sum_s[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = sum_s[WIDTH:1];
                sh_d  = {sum_s[0], sh_q[WIDTH-1:1]};
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= {WIDTH{1'b0}};
            sh_q  <= {WIDTH{1'b0}};
            b_q   <= {WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            b_q   <= b_d;
        end
    end

    // Sign correction of the finished result.
    always_comb begin
        prod_s = neg_prod ? -{acc_q, sh_q} : {acc_q, sh_q};
        if (calc_div) begin
            res_lo = neg_quo ? -sh_q : sh_q;
            res_hi = neg_rem ? -acc_q : acc_q;
        end else begin
            res_lo = prod_s[WIDTH-1:0];
            res_hi = prod_s[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: IDLE/CALC/FIX FSM, HI/LO registers and the pipeline stall request.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic [1:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mthiE,
    input  logic             mtloE,
    input  logic             hiloD,
    input  logic             mdstartD,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stallmdu
);

    logic [1:0]       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             load_s, step_s, load_dz_s;
    logic [WIDTH-1:0] res_hi_s, res_lo_s;

    assign load_dz_s = is_div_op(mdopE) && (srcbE == {WIDTH{1'b0}});

    // FSM and HI/LO next-state; an accepted op takes priority over MTHI/MTLO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdstartE) begin
                    load_s  = 1'b1;
                    div_d   = is_div_op(mdopE);
                    sa_d    = is_signed_op(mdopE) && !load_dz_s && srcaE[WIDTH-1];
                    sb_d    = is_signed_op(mdopE) && !load_dz_s && srcbE[WIDTH-1];
                    cnt_d   = {CNTW{1'b0}};
                    state_d = load_dz_s ? FIX : CALC;
                end else begin
                    if (mthiE) begin
                        hi_d = srcaE;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (mtloE) begin
                        lo_d = srcaE;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            CALC: begin
                step_s = 1'b1;
                cnt_d  = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                if (cnt_q == CNTW'(WIDTH-1)) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                hi_d    = res_hi_s;
                lo_d    = res_lo_s;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNTW{1'b0}};
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    mdu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .step     (step_s),
        .load_div (is_div_op(mdopE)),
        .load_sgn (is_signed_op(mdopE)),
        .load_dz  (load_dz_s),
        .srca     (srcaE),
        .srcb     (srcbE),
        .calc_div (div_q),
        .neg_prod (!div_q && (sa_q ^ sb_q)),
        .neg_quo  (div_q && (sa_q ^ sb_q)),
        .neg_rem  (div_q && sa_q),
        .res_hi   (res_hi_s),
        .res_lo   (res_lo_s)
    );

    // Stall must fall in the first IDLE cycle so a held MFHI/MFLO sees the new value.
    assign busy     = (state_q != IDLE);
    assign stallmdu = busy && (hiloD || mdstartD);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with hand-computed HI/LO and latency values.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        mdstartE;
    logic [1:0]  mdopE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        mthiE;
    logic        mtloE;
    logic        hiloD;
    logic        mdstartD;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stallmdu;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    mdu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .mdstartE (mdstartE),
        .mdopE    (mdopE),
        .srcaE    (srcaE),
        .srcbE    (srcbE),
        .mthiE    (mthiE),
        .mtloE    (mtloE),
        .hiloD    (hiloD),
        .mdstartD (mdstartD),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stallmdu (stallmdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with busy high after the accept edge (bounded).
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        mdopE    = op;
        srcaE    = a;
        srcbE    = b;
        mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
        count_busy(c);
        chk({tag, "_busy"}, 32'(c), 32'(exp_busy));
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset    = 1'b1;
        mdstartE = 1'b0;
        mdopE    = 2'b00;
        srcaE    = 32'h0;
        srcbE    = 32'h0;
        mthiE    = 1'b0;
        mtloE    = 1'b0;
        hiloD    = 1'b0;
        mdstartD = 1'b0;
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_stall", {31'h0, stallmdu}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg", MD_MULT, 32'hFFFFFFF9, 32'h00000003, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", MD_DIVU, 32'd100, 32'h0, 1, 32'd100, 32'hFFFFFFFF);
        run_op("div_neg_zero", MD_DIV, 32'hFFFFFFF9, 32'h0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // MFLO waiting in Decode behind MULT 5x6.
        mdopE    = MD_MULT;
        srcaE    = 32'd5;
        srcbE    = 32'd6;
        mdstartE = 1'b1;
        hiloD    = 1'b1;
        #1;
        chk("stall_accept", {31'h0, stallmdu}, 32'h0);
        tick();
        mdstartE = 1'b0;
        n = 0;
        while (stallmdu === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("stall_cycles", 32'(n), 32'd33);
        chk("stall_idle_busy", {31'h0, busy}, 32'h0);
        chk("stall_idle_lo", lo, 32'd30);
        hiloD = 1'b0;

        // Second MULT held in Decode behind MULTU 9x9.
        mdopE    = MD_MULTU;
        srcaE    = 32'd9;
        srcbE    = 32'd9;
        mdstartE = 1'b1;
        mdstartD = 1'b1;
        tick();
        mdstartE = 1'b0;
        n = 0;
        while (stallmdu === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("b2b_stall_cycles", 32'(n), 32'd33);
        chk("b2b_first_lo", lo, 32'd81);
        mdstartD = 1'b0;
        run_op("b2b_second", MD_MULT, 32'd7, 32'd8, 33, 32'h0, 32'd56);

        // MTLO alongside an accepted op is dropped.
        mdopE    = MD_MULTU;
        srcaE    = 32'd2;
        srcbE    = 32'd3;
        mdstartE = 1'b1;
        mtloE    = 1'b1;
        tick();
        mdstartE = 1'b0;
        mtloE    = 1'b0;
        chk("mtlo_ignored", lo, 32'd56);
        count_busy(n);
        chk("mtlo_op_lo", lo, 32'd6);

        mthiE = 1'b1;
        srcaE = 32'h00001234;
        tick();
        mthiE = 1'b0;
        chk("mthi_idle", hi, 32'h00001234);
        mtloE = 1'b1;
        srcaE = 32'h0000ABCD;
        tick();
        mtloE = 1'b0;
        chk("mtlo_idle", lo, 32'h0000ABCD);

        // Asynchronous reset at CALC counter=10.
        mdopE    = MD_MULTU;
        srcaE    = 32'h00001234;
        srcbE    = 32'h00000010;
        mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
        hiloD    = 1'b1;
        repeat (10) tick();
        chk("pre_rst_stall", {31'h0, stallmdu}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_hi", hi, 32'h0);
        chk("async_rst_lo", lo, 32'h0);
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        chk("async_rst_stall", {31'h0, stallmdu}, 32'h0);
        reset = 1'b0;
        hiloD = 1'b0;
        tick();
        chk("post_rst_busy", {31'h0, busy}, 32'h0);

        // DIV 0x80000000 / -1 with a spurious mdstartE mid-sequence.
        mdopE    = MD_DIV;
        srcaE    = 32'h80000000;
        srcbE    = 32'hFFFFFFFF;
        mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            mdstartE = (n == 6);
            if (n == 6) begin
                mdopE = MD_MULTU;
                srcaE = 32'd3;
                srcbE = 32'd3;
            end
            tick();
        end
        mdstartE = 1'b0;
        chk("div_wrap_busy", 32'(n), 32'd33);
        chk("div_wrap_lo", lo, 32'h80000000);
        chk("div_wrap_hi", hi, 32'h0);

        run_op("multu_min", MD_MULT, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
        run_op("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'h00000010, 33, 32'h0000000F, 32'h0FFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
